// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory responder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    // True when a byte address is misaligned or beyond the word array.
    // Any set bit above the word-index field makes the address out of range.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] word;
        word = addr >> 2;
        return (addr[1:0] != 2'b00) || ((word >> aw) != 32'd0);
    endfunction

endpackage

// File: rtl/be_word_ram.sv
// Byte-enabled 32-bit word array: synchronous write per lane, registered read.
// Contents are not reset.
module be_word_ram
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Lane-masked write and read-before-write registered read.
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS load/store path: accepts one request,
// waits WAIT_CYCLES, touches the array on entry to RESP and holds the
// response until the initiator takes it.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic        rd_ok;

    logic        accept;
    logic        enter_resp;
    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_err;
    logic [31:0] ram_rdata;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // With zero wait states the array is accessed on the accepting edge,
    // before the latches hold the request, so the live inputs are used.
    assign cur_write = (state == IDLE) ? req_write : lat_write;
    assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_be    = (state == IDLE) ? req_be    : lat_be;
    assign cur_err   = addr_err(cur_addr, ADDR_WIDTH);

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0));

    // The read port tracks the latched address during RESP, so the registered
    // read data stays stable for the whole response; rd_ok masks it to zero
    // for stores, errors and reset.
    assign resp_rdata = rd_ok ? ram_rdata : 32'd0;

    be_word_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .CLK   (CLK),
        .we    (enter_resp && cur_write && !cur_err),
        .be    (cur_be),
        .waddr (cur_addr[ADDR_WIDTH+1:2]),
        .raddr (cur_addr[ADDR_WIDTH+1:2]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // Request capture; only meaningful once accepted, so no reset needed.
    always_ff @(posedge CLK) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Control FSM and wait-state counter.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: if (cnt == 4'd0) state <= RESP;
                      else             cnt   <= cnt - 4'd1;
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Response flags, set on entry to RESP and cleared by the handshake.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok    <= 1'b0;
            resp_err <= 1'b0;
        end else if (enter_resp) begin
            rd_ok    <= !cur_write && !cur_err;
            resp_err <= cur_err;
        end else if ((state == RESP) && resp_ready) begin
            rd_ok    <= 1'b0;
            resp_err <= 1'b0;
        end
    end

endmodule
